// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// Provides the default register-file geometry, the write-controller state
// encoding and the round-robin priority encoding.
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADR_W  = 3;
  localparam int RF_NREGS  = 1 << RF_ADR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wr_state_t;

  // Which requester gets the next tie-break.
  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   req[1:0]    - request vector, bit 0 = A, bit 1 = B
//   enable      - when low no grant is issued and priority is frozen
//   gnt[1:0]    - combinational grant, one-hot or zero
// Priority flips to the other requester after each grant, so two
// continuously requesting clients alternate.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic prio_q;

  // A lone requester wins outright; the priority bit only breaks ties.
  assign gnt[0] = enable & req[0] & (~req[1] | (prio_q == PRIO_A));
  assign gnt[1] = enable & req[1] & (~req[0] | (prio_q == PRIO_B));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= PRIO_A;
    end else if (gnt[0]) begin
      prio_q <= PRIO_B;
    end else if (gnt[1]) begin
      prio_q <= PRIO_A;
    end
  end

endmodule : rr_arb2

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single register-file write port and shares
// it between requester A (ALU writeback) and requester B (load return).
// After reset it first writes INIT_VAL to every register (INIT), then
// arbitrates round-robin between A and B (RUN).
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   a_valid/a_adr/a_data/a_ready  - requester A handshake (ready is combinational)
//   b_valid/b_adr/b_data/b_ready  - requester B handshake (ready is combinational)
//   W_Adr, we, W                  - registered register-file write port
//   busy                          - high while the init sequence runs
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = RF_DATA_W,
  parameter int                ADR_W     = RF_ADR_W,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0,
  parameter bit                SKIP_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADR_W-1:0]  a_adr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADR_W-1:0]  b_adr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADR_W-1:0]  W_Adr,
  output logic              we,
  output logic [DATA_W-1:0] W,
  output logic              busy
);

  localparam wr_state_t RESET_STATE = SKIP_INIT ? ST_RUN : ST_INIT;

  wr_state_t         state_q, state_d;
  logic [ADR_W-1:0]  cnt_q, cnt_d;
  logic              we_d;
  logic [ADR_W-1:0]  adr_d;
  logic [DATA_W-1:0] data_d;

  logic              arb_en;
  logic [1:0]        gnt;
  logic [ADR_W-1:0]  win_adr;
  logic [DATA_W-1:0] win_data;

  // Readies stay low while reset is held, even when SKIP_INIT puts the
  // state register straight into RUN.
  assign arb_en = (state_q == ST_RUN) && !reset;
  assign busy   = (state_q == ST_INIT);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({b_valid, a_valid}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // Write-data mux: grants are mutually exclusive, so B is selected only
  // when it holds the grant.
  assign win_adr  = gnt[1] ? b_adr  : a_adr;
  assign win_data = gnt[1] ? b_data : a_data;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    adr_d   = W_Adr;
    data_d  = W;
    unique case (state_q)
      ST_INIT: begin
        we_d   = 1'b1;
        adr_d  = cnt_q;
        data_d = INIT_VAL;
        cnt_d  = cnt_q + 1'b1;
        // The edge that writes the last register also enters RUN; cnt wraps
        // back to 0, ready for the next reset-free restart.
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (gnt != 2'b00) begin
          we_d   = 1'b1;
          adr_d  = win_adr;
          data_d = win_data;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      we      <= 1'b0;
      W_Adr   <= '0;
      W       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we      <= we_d;
      W_Adr   <= adr_d;
      W       <= data_d;
    end
  end

endmodule : regfile_write_arbiter

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port controller for the 8 x 16-bit register file (`Register_File`). It shares the single write port (`W_Adr`, `we`, `W`) between two requesters, A (ALU writeback) and B (load/memory return), using valid/ready handshakes and fair round-robin priority. After every reset it runs an init sequence that writes `INIT_VAL` to all eight registers before accepting any request. It sits between the execution datapath and the register file; the read ports are not touched.

## Interface
- `DATA_W`, 16, register width.
- `ADR_W`, 3, register address width; the register count is 2^ADR_W.
- `INIT_VAL`, 16'h0000, value written to every register by the init sequence.
- `SKIP_INIT`, 0, when 1 the block enters RUN directly after reset.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A holds a write.
- `a_adr`  in  ADR_W  A target register.
- `a_data`  in  DATA_W  A write data.
- `a_ready`  out  1  A transfer accepted this cycle (combinational).
- `b_valid`, `b_adr`, `b_data`, `b_ready`  same as the A ports, for requester B.
- `W_Adr`  out  ADR_W  register-file write address (registered).
- `we`  out  1  register-file write enable (registered).
- `W`  out  DATA_W  register-file write data (registered).
- `busy`  out  1  high while the init sequence runs.

## Operation
- States: INIT, RUN. Reset puts the block in INIT, or in RUN when `SKIP_INIT`=1.
- **INIT:**
  - A 3-bit counter `cnt` starts at 0.
  - Each posedge registers `we`=1, `W_Adr`=`cnt`, `W`=`INIT_VAL`, then increments `cnt`.
  - The posedge that registers `cnt`=7 also moves the state to RUN.
  - `a_ready` and `b_ready` are forced to 0 throughout INIT.
- **RUN, arbitration:**
  - One-bit priority register `prio`; reset value = A.
  - `a_ready` = RUN & `a_valid` & (!`b_valid` | `prio`==A).
  - `b_ready` = RUN & `b_valid` & (!`a_valid` | `prio`==B).
  - At most one ready is high per cycle.
- **RUN, transfer:** a transfer occurs when valid & ready at a posedge. That edge registers `we`=1, `W_Adr`=winner adr, `W`=winner data.
- **RUN, priority update:** after granting A, `prio` becomes B; after granting B, `prio` becomes A. `prio` is unchanged on cycles with no grant.
- **RUN, idle:** with no transfer, `we`=0. `W_Adr` and `W` hold their last values.
- **Requester rules:**
  - A requester keeps valid, adr and data stable until it sees ready.
  - Valid must not depend on ready.
- **Same-address collisions:** A and B targeting the same register are serialized in grant order; the later write wins in the register file.

## Timing
- Reset values (asynchronous):
  - State INIT (RUN if `SKIP_INIT`), `cnt`=0, `prio`=A.
  - `we`=0, `W_Adr`=0, `W`=0.
  - `busy`=1 (0 if `SKIP_INIT`); `a_ready`=`b_ready`=0.
- INIT lasts exactly 8 posedges after reset deasserts. `busy` falls after the 8th posedge, and ready may assert in the following cycle.
- Write latency:
  - A request accepted at posedge k appears on `we`/`W_Adr`/`W` after edge k.
  - The register file captures it at edge k+1.
  - Data is readable on R/S after edge k+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate A, B, A, B.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs return to reset values immediately.
  - Any accepted but not yet committed write is dropped.
  - INIT restarts from register 0.

## Structure
- Shared package `regfile_pkg`:
  - Constants `RF_DATA_W`=16, `RF_ADR_W`=3, `RF_NREGS`=8.
  - State enum `wr_state_t` {ST_INIT, ST_RUN}.
  - Priority encoding `PRIO_A`=0, `PRIO_B`=1.
- Sub-module `rr_arb2`: a 2-way round-robin arbiter holding `prio`. Inputs: `clk`, `reset`, req[1:0], enable. Outputs: gnt[1:0], one-hot or zero.
- Top level contains: the INIT counter, the state register, the output registers, and the write-data mux.

## Test plan
- **Reset then idle:** pulse `reset`; hold valids low.
  - `we`=1 for 8 consecutive cycles with `W_Adr` 0..7 and `W`=0000.
  - `busy` falls, then `we`=0; reading all registers returns 0000.
- **Single A write:** `a_valid`, `a_adr`=3, `a_data`=BEEF in RUN.
  - `a_ready`=1 that cycle; next cycle `we`=1, `W_Adr`=3, `W`=BEEF.
  - R_Adr=3 reads BEEF one cycle later.
- **Both continuously valid:** A writes regs 0–3 (1111 to 4444), B writes regs 4–7 (AAAA to DDDD).
  - Grants alternate A,B,A,B,… starting with A.
  - All 8 writes complete in 8 cycles; readback matches.
- **Same-address collision:** A and B both target reg 5 (A=1234, B=5678), with `prio`=B.
  - B is granted first, then A; reg 5 reads 1234.
- **Request during INIT:** assert `a_valid` immediately after reset.
  - `a_ready`=0 until `busy` falls; the write then lands after the init values.
- **Reset mid-RUN:** assert `reset` the cycle after `a_ready`.
  - `we` drops to 0 asynchronously and the pending write is lost.
  - INIT restarts at `W_Adr`=0.
